// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM
// states, MMIO register offsets and the store byte-lane helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        WORD = 2'b00,
        BYTE = 2'b01,
        HALF = 2'b10,
        RSVD = 2'b11
    } access_e;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Offsets inside the MMIO page (address bits [27:0], word aligned)
    localparam logic [27:0] TOHOST = 28'h000_0000;
    localparam logic [27:0] CYCLE  = 28'h000_0004;
    localparam logic [27:0] STATUS = 28'h000_0008;

    // Byte lanes touched by a store; all-zero means the store is illegal
    // (misaligned or reserved size).
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        m = 4'b0000;
        case (access_e'(size))
            WORD: begin
                if (lo == 2'b00) m = 4'b1111;
                else             m = 4'b0000;
            end
            HALF: begin
                if (lo[0] == 1'b0) m = lo[1] ? 4'b1100 : 4'b0011;
                else               m = 4'b0000;
            end
            BYTE:    m = 4'b0001 << lo;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 RAM with per-byte write enables and a registered read port
// that returns the contents from before a same-edge write.
module dmem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Byte-lane write into the array; the array itself is never reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Synchronous read; non-blocking semantics give read-old-data
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata_r <= 32'h0000_0000;
        else if (re) rdata_r <= mem_r[raddr];
        else         rdata_r <= rdata_r;
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: clears its RAM after reset, then serves byte,
// halfword and word stores plus a small MMIO page (tohost, cycle counter,
// fault status). Read data lines up with the core's writeback stage.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic [1:0]  ByteAccessM,
    output logic [31:0] ReadData,
    output logic        InitDone,
    output logic [31:0] ToHost,
    output logic        ToHostValid,
    output logic        MisalignFault
);

    localparam int AW = $clog2(DEPTH);

    // Source of ReadData for the current cycle
    localparam logic [1:0] SRC_ZERO = 2'b00;
    localparam logic [1:0] SRC_RAM  = 2'b01;
    localparam logic [1:0] SRC_MMIO = 2'b10;

    state_e        state_r;
    logic [AW-1:0] sweep_r;
    logic          init_done_r;
    logic [31:0]   tohost_r;
    logic          tohost_valid_r;
    logic          fault_r;
    logic [31:0]   cycle_r;
    logic [1:0]    rd_src_r;
    logic [31:0]   mmio_rdata_r;

    logic          is_mmio_s;
    logic [27:0]   mmio_off_s;
    logic [3:0]    lanes_s;
    logic          store_s;
    logic          tohost_hit_s;
    logic          tohost_wr_s;
    logic          fault_set_s;
    logic [31:0]   mmio_val_s;
    logic [3:0]    ram_we_s;
    logic [AW-1:0] ram_waddr_s;
    logic [31:0]   ram_wdata_s;
    logic          ram_re_s;
    logic [31:0]   ram_rdata_s;

    // Address decode, lane generation and fault detection
    always_comb begin
        is_mmio_s    = (ALUResultM[31:28] == MMIO_BASE[31:28]);
        mmio_off_s   = {ALUResultM[27:2], 2'b00};
        lanes_s      = lane_mask(ByteAccessM, ALUResultM[1:0]);
        store_s      = (state_r == RUN) && MemWriteM;
        tohost_hit_s = is_mmio_s && (mmio_off_s == TOHOST);
        tohost_wr_s  = store_s && tohost_hit_s && (lanes_s == 4'b1111)
                       && (access_e'(ByteAccessM) == WORD);
        if (!store_s)          fault_set_s = 1'b0;
        else if (!is_mmio_s)   fault_set_s = (lanes_s == 4'b0000);
        else if (tohost_hit_s) fault_set_s = !tohost_wr_s;
        else                   fault_set_s = 1'b0;
    end

    // MMIO read value for the addressed register
    always_comb begin
        case (mmio_off_s)
            TOHOST:  mmio_val_s = tohost_r;
            CYCLE:   mmio_val_s = cycle_r;
            STATUS:  mmio_val_s = {31'h0000_0000, fault_r};
            default: mmio_val_s = 32'h0000_0000;
        endcase
    end

    // RAM port drive: clearing sweep in INIT, core stores/reads in RUN
    always_comb begin
        ram_waddr_s = ALUResultM[AW+1:2];
        ram_re_s    = 1'b0;
        if (state_r == INIT) begin
            ram_we_s    = 4'b1111;
            ram_waddr_s = sweep_r;
            ram_wdata_s = 32'h0000_0000;
        end else begin
            ram_re_s = !is_mmio_s;
            if (MemWriteM && !is_mmio_s) ram_we_s = lanes_s;
            else                         ram_we_s = 4'b0000;
            case (access_e'(ByteAccessM))
                HALF:    ram_wdata_s = {2{WriteDataM[15:0]}};
                BYTE:    ram_wdata_s = {4{WriteDataM[7:0]}};
                default: ram_wdata_s = WriteDataM;
            endcase
        end
    end

    dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (ram_re_s),
        .raddr (ALUResultM[AW+1:2]),
        .rdata (ram_rdata_s)
    );

    // FSM, clearing sweep and free-running cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= INIT;
            sweep_r     <= '0;
            init_done_r <= 1'b0;
            cycle_r     <= 32'h0000_0000;
        end else begin
            case (state_r)
                INIT: begin
                    sweep_r <= sweep_r + AW'(1);
                    cycle_r <= 32'h0000_0000;
                    if (sweep_r == AW'(DEPTH - 1)) begin
                        state_r     <= RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= INIT;
                        init_done_r <= 1'b0;
                    end
                end
                RUN: begin
                    cycle_r     <= cycle_r + 32'h0000_0001;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= INIT;
                    sweep_r     <= '0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // MMIO side effects: tohost register, its strobe and the sticky fault
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tohost_r       <= 32'h0000_0000;
            tohost_valid_r <= 1'b0;
            fault_r        <= 1'b0;
        end else begin
            tohost_valid_r <= tohost_wr_s;
            if (tohost_wr_s) tohost_r <= WriteDataM;
            else             tohost_r <= tohost_r;
            fault_r <= fault_r | fault_set_s;
        end
    end

    // Read pipeline: remember the source and capture MMIO data at the edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_src_r     <= SRC_ZERO;
            mmio_rdata_r <= 32'h0000_0000;
        end else if (state_r == RUN) begin
            rd_src_r     <= is_mmio_s ? SRC_MMIO : SRC_RAM;
            mmio_rdata_r <= mmio_val_s;
        end else begin
            rd_src_r     <= SRC_ZERO;
            mmio_rdata_r <= 32'h0000_0000;
        end
    end

    // ReadData mux over registered sources
    always_comb begin
        case (rd_src_r)
            SRC_RAM:  ReadData = ram_rdata_s;
            SRC_MMIO: ReadData = mmio_rdata_r;
            default:  ReadData = 32'h0000_0000;
        endcase
    end

    assign InitDone      = init_done_r;
    assign ToHost        = tohost_r;
    assign ToHostValid   = tohost_valid_r;
    assign MisalignFault = fault_r;

endmodule
